// File: rtl/packet_rr_arbiter_if.sv
// Avalon-ST bundle for packet_rr_arbiter: NUM_INPUTS packet sinks in, one channel-tagged source out.
interface packet_rr_arbiter_if #(
    parameter int NUM_INPUTS    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_WIDTH = 2
);
    logic [NUM_INPUTS*DATA_WIDTH-1:0] asi_in_data;
    logic [NUM_INPUTS-1:0]            asi_in_valid;
    logic [NUM_INPUTS-1:0]            asi_in_startofpacket;
    logic [NUM_INPUTS-1:0]            asi_in_endofpacket;
    logic [NUM_INPUTS-1:0]            asi_in_ready;
    logic [DATA_WIDTH-1:0]            aso_out_data;
    logic                             aso_out_valid;
    logic                             aso_out_startofpacket;
    logic                             aso_out_endofpacket;
    logic [CHANNEL_WIDTH-1:0]         aso_out_channel;
    logic                             aso_out_ready;
    logic [NUM_INPUTS-1:0]            err_orphan;

    modport slave (
        input  asi_in_data, asi_in_valid, asi_in_startofpacket, asi_in_endofpacket, aso_out_ready,
        output asi_in_ready, aso_out_data, aso_out_valid, aso_out_startofpacket,
               aso_out_endofpacket, aso_out_channel, err_orphan
    );

    modport master (
        output asi_in_data, asi_in_valid, asi_in_startofpacket, asi_in_endofpacket, aso_out_ready,
        input  asi_in_ready, aso_out_data, aso_out_valid, aso_out_startofpacket,
               aso_out_endofpacket, aso_out_channel, err_orphan
    );
endinterface

// File: rtl/packet_rr_arbiter.sv
// Packet-granular round-robin arbiter: holds a grant from SOP to EOP and forwards beats
// through one registered output stage tagged with the source channel.
module packet_rr_arbiter #(
    parameter int NUM_INPUTS    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_WIDTH = 2
) (
    input  logic                clock_clk,
    input  logic                reset_reset,
    packet_rr_arbiter_if.slave  st
);
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                   state_q, state_d;
    logic [CHANNEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [CHANNEL_WIDTH-1:0] grant_q, grant_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_sop_q, out_sop_d;
    logic                     out_eop_q, out_eop_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [CHANNEL_WIDTH-1:0] out_ch_q, out_ch_d;
    logic [NUM_INPUTS-1:0]    err_q, err_d;

    logic                     can_load;
    logic                     take;
    logic                     sel_valid, sel_sop, sel_eop;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [NUM_INPUTS-1:0]    ready;
    logic [NUM_INPUTS-1:0]    req;
    logic [NUM_INPUTS-1:0]    req_rot;

    function automatic logic [CHANNEL_WIDTH-1:0] wrap_add(input logic [CHANNEL_WIDTH-1:0] base,
                                                          input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_INPUTS) sum = sum - NUM_INPUTS;
        return CHANNEL_WIDTH'(sum);
    endfunction

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_ch_d    = out_ch_q;
        err_d       = '0;
        ready       = '0;
        sel_valid   = 1'b0;
        sel_sop     = 1'b0;
        sel_eop     = 1'b0;
        sel_data    = '0;

        can_load    = !out_valid_q || st.aso_out_ready;
        out_valid_d = can_load ? 1'b0 : out_valid_q;
        req         = st.asi_in_valid & st.asi_in_startofpacket;
        req_rot     = NUM_INPUTS'({req, req} >> ptr_q);

        // Granted input follows the output register; any other non-SOP beat is swallowed as an orphan.
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (state_q == LOCKED && i == int'(grant_q)) begin
                ready[i]  = can_load;
                sel_valid = st.asi_in_valid[i];
                sel_sop   = st.asi_in_startofpacket[i];
                sel_eop   = st.asi_in_endofpacket[i];
                sel_data  = st.asi_in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (st.asi_in_valid[i] && !st.asi_in_startofpacket[i]) begin
                ready[i] = 1'b1;
                err_d[i] = 1'b1;
            end
        end

        take = (state_q == LOCKED) && can_load && sel_valid;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sop_d   = sel_sop;
            out_eop_d   = sel_eop;
            out_ch_d    = grant_q;
            if (sel_eop) begin
                state_d = IDLE;
                ptr_d   = wrap_add(grant_q, 1);
            end
        end

        // Descending scan so the requester closest at-or-after the pointer is the one kept.
        if (state_q == IDLE) begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                if (req_rot[k]) begin
                    state_d = LOCKED;
                    grant_d = wrap_add(ptr_q, k);
                end
            end
        end

        if (reset_reset) ready = '0;
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            err_q       <= err_d;
        end
    end

    assign st.asi_in_ready          = ready;
    assign st.aso_out_valid         = out_valid_q;
    assign st.aso_out_data          = out_data_q;
    assign st.aso_out_startofpacket = out_sop_q;
    assign st.aso_out_endofpacket   = out_eop_q;
    assign st.aso_out_channel       = out_ch_q;
    assign st.err_orphan            = err_q;
endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Bench for packet_rr_arbiter: packet sources, a rule-level reference model, an end-to-end
// per-channel scoreboard, directed scenarios with literal expectations, then random traffic.
module tb_packet_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_rr_arbiter_if #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .CHANNEL_WIDTH(CW)) bus ();

    packet_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .CHANNEL_WIDTH(CW)) dut (
        .clock_clk   (clk),
        .reset_reset (rst),
        .st          (bus.slave)
    );

    typedef struct { logic [DW-1:0] d; int ch; bit sop; bit eop; int cyc; } beat_t;

    int chk  = 0;
    int pass = 0;
    int cyc  = 0;

    // Sources
    int          src_len [N];
    int          src_pos [N];
    int          src_save[N];
    logic [DW-1:0] src_data[N][16];
    bit          orph_req [N];
    logic [DW-1:0] orph_data[N];
    bit          gaps        = 1'b0;
    bit          auto_reload = 1'b0;
    int          ready_mode  = 1;
    int          stall_cnt   = 0;
    logic [DW-1:0] stall_data = '0;

    // Reference model
    bit          model_ok = 1'b0;
    bit          m_locked;
    int          m_owner, m_ptr;
    bit          m_ov, m_sop, m_eop;
    logic [DW-1:0] m_data;
    int          m_ch;
    bit [N-1:0]  m_err;

    // Scoreboard and observation
    logic [DW+1:0] exp_q[N][$];
    beat_t       log_q[$];
    int          err_cnt[N];
    bit          out_inpkt = 1'b0;
    int          out_ch    = 0;
    logic        seen_ov, seen_sop, seen_eop;
    logic [DW-1:0] seen_data;
    logic [CW-1:0] seen_ch;
    logic [N-1:0]  seen_err, seen_ready;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act === exp) pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    task automatic load_pkt(input int i, input int len, input logic [DW-1:0] base, input int stp);
        src_len[i]  = len;
        src_save[i] = len;
        src_pos[i]  = 0;
        for (int b = 0; b < len; b++) src_data[i][b] = DW'(int'(base) + b * stp);
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++)
            if (src_len[i] != 0 || orph_req[i] || exp_q[i].size() != 0) return 1'b0;
        return !m_ov;
    endfunction

    function automatic int sop_count();
        int n = 0;
        foreach (log_q[k]) if (log_q[k].sop) n++;
        return n;
    endfunction

    task automatic step(input bit do_rst);
        bit [N-1:0] v, s, e, orph, xr;
        logic [N*DW-1:0] d;
        bit oready, can_load, found;
        int j, own;
        beat_t b;
        logic [DW+1:0] ex;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            orph[i] = 1'b0; v[i] = 1'b0; s[i] = 1'b0; e[i] = 1'b0;
            d[i*DW +: DW] = DW'($urandom);
            if (src_len[i] == 0 && orph_req[i]) begin
                v[i] = 1'b1; orph[i] = 1'b1; d[i*DW +: DW] = orph_data[i];
            end else if (src_len[i] > 0) begin
                v[i] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                s[i] = (src_pos[i] == 0);
                e[i] = (src_pos[i] == src_len[i] - 1);
                d[i*DW +: DW] = src_data[i][src_pos[i]];
            end
        end
        case (ready_mode)
            1: oready = 1'b1;
            2: begin
                oready = !(bus.aso_out_valid && bus.aso_out_data == stall_data && stall_cnt < 3);
                if (!oready) stall_cnt++;
            end
            default: oready = ($urandom_range(0, 3) != 0);
        endcase
        rst = do_rst;
        bus.asi_in_valid         = v;
        bus.asi_in_startofpacket = s;
        bus.asi_in_endofpacket   = e;
        bus.asi_in_data          = d;
        bus.aso_out_ready        = oready;
        #1;
        seen_ov = bus.aso_out_valid;  seen_data = bus.aso_out_data;
        seen_sop = bus.aso_out_startofpacket; seen_eop = bus.aso_out_endofpacket;
        seen_ch = bus.aso_out_channel; seen_err = bus.err_orphan; seen_ready = bus.asi_in_ready;

        can_load = !m_ov || oready;
        for (int i = 0; i < N; i++)
            xr[i] = do_rst ? 1'b0 : (m_locked && i == m_owner) ? can_load : (v[i] && !s[i]);

        if (model_ok) begin
            check("out_valid", seen_ov, m_ov);
            if (m_ov) begin
                check("out_data", seen_data, m_data);
                check("out_sop", seen_sop, m_sop);
                check("out_eop", seen_eop, m_eop);
                check("out_channel", seen_ch, m_ch);
            end
            check("err_orphan", seen_err, m_err);
            check("in_ready", seen_ready, xr);
            for (int i = 0; i < N; i++) if (seen_err[i] === 1'b1) err_cnt[i]++;
            if (!do_rst && seen_ov === 1'b1 && oready) begin
                b.d = seen_data; b.ch = int'(seen_ch); b.sop = seen_sop; b.eop = seen_eop; b.cyc = cyc;
                log_q.push_back(b);
                if (exp_q[b.ch].size() == 0) begin
                    check("sb_unexpected_beat", {b.d, b.sop, b.eop}, 32'hFFFF_FFFF);
                end else begin
                    ex = exp_q[b.ch].pop_front();
                    check("sb_beat", {b.d, b.sop, b.eop}, ex);
                end
                if (out_inpkt) check("no_interleave", b.ch, out_ch);
                if (b.sop) begin out_inpkt = 1'b1; out_ch = b.ch; end
                if (b.eop) out_inpkt = 1'b0;
            end
        end

        // Reference model: state after this edge.
        if (do_rst) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_ov = 0; m_sop = 0; m_eop = 0;
            m_data = '0; m_ch = 0; m_err = '0; out_inpkt = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) m_err[i] = v[i] && !s[i] && !(m_locked && i == m_owner);
            if (can_load) m_ov = 1'b0;
            if (m_locked) begin
                own = m_owner;
                if (v[own] && can_load) begin
                    m_ov = 1'b1; m_data = d[own*DW +: DW]; m_sop = s[own]; m_eop = e[own]; m_ch = own;
                    if (e[own]) begin m_locked = 1'b0; m_ptr = (own + 1) % N; end
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!found && v[j] && s[j]) begin found = 1'b1; m_locked = 1'b1; m_owner = j; end
                end
            end
        end

        // Sources advance on handshakes.
        for (int i = 0; i < N; i++) begin
            if (do_rst) begin
                if (src_pos[i] > 0) src_len[i] = 0;
                exp_q[i].delete();
            end else if (v[i] && xr[i]) begin
                if (orph[i]) orph_req[i] = 1'b0;
                else begin
                    exp_q[i].push_back({d[i*DW +: DW], s[i], e[i]});
                    src_pos[i]++;
                    if (src_pos[i] == src_len[i]) begin
                        src_pos[i] = 0;
                        src_len[i] = auto_reload ? src_save[i] : 0;
                    end
                end
            end
        end
        if (do_rst) model_ok = 1'b1;
        cyc++;
    endtask

    task automatic run_idle(input string nm, input int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin step(1'b0); n++; end
        check(nm, all_idle(), 1'b1);
    endtask

    initial begin
        int n, start, k, aa_hits;
        bus.asi_in_valid = '0; bus.asi_in_startofpacket = '0; bus.asi_in_endofpacket = '0;
        bus.asi_in_data = '0; bus.aso_out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0; src_pos[i] = 0; src_save[i] = 0; orph_req[i] = 0; err_cnt[i] = 0;
        end

        // Reset state
        step(1'b1); step(1'b1); step(1'b0);
        check("rst_valid", seen_ov, 1'b0);  check("rst_data", seen_data, 8'h00);
        check("rst_channel", seen_ch, 2'd0); check("rst_ready", seen_ready, 4'h0);
        check("rst_err", seen_err, 4'h0);

        // Single 4-beat packet from input 2
        log_q.delete();
        load_pkt(2, 4, 8'h11, 8'h11);
        start = cyc;
        run_idle("d1_drain", 40);
        check("d1_beats", log_q.size(), 4);
        for (int b = 0; b < 4 && b < log_q.size(); b++) begin
            check("d1_data", log_q[b].d, 8'h11 * (b + 1));
            check("d1_channel", log_q[b].ch, 2);
            check("d1_sop", log_q[b].sop, b == 0);
            check("d1_eop", log_q[b].eop, b == 3);
            check("d1_cycle", log_q[b].cyc, start + 2 + b);
        end

        // All inputs continuously requesting 2-beat packets
        step(1'b1);
        log_q.delete();
        for (int i = 0; i < N; i++) load_pkt(i, 2, 8'h10 * (i + 1), 1);
        auto_reload = 1'b1;
        n = 0;
        while (sop_count() < 5 && n < 60) begin step(1'b0); n++; end
        auto_reload = 1'b0;
        run_idle("d2_drain", 80);
        k = 0;
        foreach (log_q[b]) if (log_q[b].sop && k < 5) begin
            check("d2_grant_order", log_q[b].ch, k % N);
            k++;
        end
        check("d2_packets", k, 5);

        // Output backpressure on beat 2
        step(1'b1);
        log_q.delete();
        ready_mode = 2; stall_cnt = 0; stall_data = 8'h02;
        load_pkt(0, 4, 8'h01, 1);
        run_idle("d3_drain", 40);
        ready_mode = 1;
        check("d3_stalls", stall_cnt, 3);
        check("d3_beats", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int b = 0; b < 4; b++) check("d3_data", log_q[b].d, b + 1);
            check("d3_stall_gap", log_q[1].cyc - log_q[0].cyc, 4);
            check("d3_resume_gap", log_q[2].cyc - log_q[1].cyc, 1);
        end

        // Orphan beat on input 1 while input 0 is locked
        log_q.delete();
        for (int i = 0; i < N; i++) err_cnt[i] = 0;
        load_pkt(0, 4, 8'h50, 1);
        n = 0;
        do begin step(1'b0); n++; end while (seen_ready[0] !== 1'b1 && n < 20);
        check("d4_grant", seen_ready[0], 1'b1);
        orph_req[1] = 1'b1; orph_data[1] = 8'hAA;
        step(1'b0);
        check("d4_orphan_ready", seen_ready[1], 1'b1);
        run_idle("d4_drain", 40);
        check("d4_err1_pulses", err_cnt[1], 1);
        check("d4_err0_pulses", err_cnt[0], 0);
        aa_hits = 0;
        foreach (log_q[b]) if (log_q[b].d == 8'hAA) aa_hits++;
        check("d4_orphan_dropped", aa_hits, 0);
        check("d4_beats", log_q.size(), 4);

        // Reset mid-packet from input 3 restores pointer 0
        load_pkt(3, 5, 8'h30, 1);
        n = 0;
        while (src_pos[3] != 2 && n < 20) begin step(1'b0); n++; end
        check("d5_reach_beat3", src_pos[3], 2);
        step(1'b1);
        step(1'b0);
        check("d5_valid", seen_ov, 1'b0);  check("d5_data", seen_data, 8'h00);
        check("d5_sop", seen_sop, 1'b0);   check("d5_eop", seen_eop, 1'b0);
        check("d5_channel", seen_ch, 2'd0); check("d5_err", seen_err, 4'h0);
        check("d5_ready", seen_ready, 4'h0);
        log_q.delete();
        load_pkt(3, 2, 8'h61, 1);
        load_pkt(0, 2, 8'h71, 1);
        run_idle("d5_drain", 40);
        check("d5_beats", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("d5_first_ch", log_q[0].ch, 0);
            check("d5_second_ch", log_q[2].ch, 3);
        end

        // Back-to-back single-beat packets from inputs 1 and 3
        log_q.delete();
        load_pkt(1, 1, 8'hB1, 0);
        load_pkt(3, 1, 8'hB3, 0);
        run_idle("d6_drain", 40);
        check("d6_beats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("d6_ch_a", log_q[0].ch, 1);   check("d6_ch_b", log_q[1].ch, 3);
            check("d6_flags_a", {log_q[0].sop, log_q[0].eop}, 2'b11);
            check("d6_flags_b", {log_q[1].sop, log_q[1].eop}, 2'b11);
            check("d6_bubble", log_q[1].cyc - log_q[0].cyc, 2);
        end

        // Random traffic: gaps, backpressure, orphans, occasional reset
        step(1'b1);
        gaps = 1'b1; ready_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_len[i] == 0 && !orph_req[i]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        src_len[i] = $urandom_range(1, 6); src_save[i] = src_len[i]; src_pos[i] = 0;
                        for (int b = 0; b < 16; b++) src_data[i][b] = DW'($urandom);
                    end else if ($urandom_range(0, 39) == 0) begin
                        orph_req[i] = 1'b1; orph_data[i] = DW'($urandom);
                    end
                end
            end
            step($urandom_range(0, 499) == 0);
        end
        run_idle("rand_drain", 2000);

        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
